// File: rtl/data_cache_ctrl_pkg.sv
// Shared constants, FSM state encoding and address helpers for the data cache controller.
// No logic, no latency; no flow control.
// Used by the controller and its line store.
package data_cache_ctrl_pkg;
    localparam int ADDR_W   = 16;
    localparam int WORD_W   = 16;
    localparam int OFFSET_W = 2;
    localparam int LINE_W   = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_WRITE   = 2'd2,
        ST_RESPOND = 2'd3
    } state_e;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction
endpackage

// File: rtl/data_cache_ctrl_line_store.sv
// Direct-mapped valid/tag/data arrays with combinational lookup.
// Lookup is 0 cycles; word write and line fill take effect at the next edge.
// No backpressure: writes and fills are always accepted.
module cache_line_store
    import data_cache_ctrl_pkg::*;
#(
    parameter int NUM_LINES      = 4,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [ADDR_W-1:0]                addr,
    output logic                             hit,
    output logic [WORD_W-1:0]                word,
    input  logic                             wr_en,
    input  logic [WORD_W-1:0]                wr_data,
    input  logic                             fill_en,
    input  logic [WORDS_PER_LINE*WORD_W-1:0] fill_line
);
    localparam int IB    = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - OFFSET_W - IB;

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [TAG_W-1:0]     tag_d  [NUM_LINES];
    logic [WORD_W-1:0]    data_q [NUM_LINES][WORDS_PER_LINE];
    logic [WORD_W-1:0]    data_d [NUM_LINES][WORDS_PER_LINE];

    logic [IB-1:0]       idx;
    logic [TAG_W-1:0]    tag;
    logic [OFFSET_W-1:0] off;

    assign idx  = addr[OFFSET_W+IB-1:OFFSET_W];
    assign tag  = addr[ADDR_W-1:OFFSET_W+IB];
    assign off  = addr[OFFSET_W-1:0];
    assign hit  = valid_q[idx] && (tag_q[idx] == tag);
    assign word = data_q[idx][off];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d[idx] = 1'b1;
            tag_d[idx]   = tag;
            for (int k = 0; k < WORDS_PER_LINE; k++) begin
                data_d[idx][k] = fill_line[k*WORD_W +: WORD_W];
            end
        end else if (wr_en) begin
            data_d[idx][off] = wr_data;
        end
    end

    // Only the valid bits need clearing; stale tags/data are unreachable.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
        tag_q  <= tag_d;
        data_q <= data_d;
    end
endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller with hit/miss counters.
// Read hit 0-cycle stall; miss/write stall until mem_ready, then one RESPOND cycle.
// Stalls the datapath via mem_access_done=0; memory requests held until mem_ready.
module data_cache_ctrl
    import data_cache_ctrl_pkg::*;
#(
    parameter int NUM_LINES      = 4,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              is_hit,
    output logic              is_miss,
    output logic              mem_access_done,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rline,
    input  logic              mem_ready,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              is_rd_q, is_rd_d;
    logic [15:0]       hit_count_q, hit_count_d;
    logic [15:0]       miss_count_q, miss_count_d;

    logic [ADDR_W-1:0] lookup_addr;
    logic              lk_hit;
    logic [WORD_W-1:0] lk_word;
    logic              st_wr_en;
    logic              st_fill_en;

    cache_line_store #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_store (
        .clk       (clk),
        .reset     (reset),
        .addr      (lookup_addr),
        .hit       (lk_hit),
        .word      (lk_word),
        .wr_en     (st_wr_en),
        .wr_data   (cpu_wdata),
        .fill_en   (st_fill_en),
        .fill_line (mem_rline)
    );

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        is_rd_d         = is_rd_q;
        hit_count_d     = hit_count_q;
        miss_count_d    = miss_count_q;
        // The live CPU address is only looked up in IDLE; afterwards the latched one is.
        lookup_addr     = (state_q == ST_IDLE) ? cpu_addr : addr_q;
        is_hit          = 1'b0;
        is_miss         = 1'b0;
        mem_access_done = 1'b1;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        cpu_rdata       = '0;
        st_wr_en        = 1'b0;
        st_fill_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_write) begin
                    is_hit          = lk_hit;
                    is_miss         = !lk_hit;
                    mem_access_done = 1'b0;
                    st_wr_en        = lk_hit;
                    addr_d          = cpu_addr;
                    wdata_d         = cpu_wdata;
                    is_rd_d         = 1'b0;
                    state_d         = ST_WRITE;
                end else if (cpu_read) begin
                    if (lk_hit) begin
                        is_hit    = 1'b1;
                        cpu_rdata = lk_word;
                    end else begin
                        is_miss         = 1'b1;
                        mem_access_done = 1'b0;
                        addr_d          = cpu_addr;
                        is_rd_d         = 1'b1;
                        state_d         = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                mem_read        = 1'b1;
                mem_addr        = line_base(addr_q);
                mem_access_done = 1'b0;
                if (mem_ready) begin
                    st_fill_en = 1'b1;
                    state_d    = ST_RESPOND;
                end
            end
            ST_WRITE: begin
                mem_write       = 1'b1;
                mem_addr        = addr_q;
                mem_wdata       = wdata_q;
                mem_access_done = 1'b0;
                if (mem_ready) begin
                    state_d = ST_RESPOND;
                end
            end
            default: begin
                if (is_rd_q) begin
                    cpu_rdata = lk_word;
                end
                state_d = ST_IDLE;
            end
        endcase

        if (is_hit) begin
            hit_count_d = hit_count_q + 16'd1;
        end
        if (is_miss) begin
            miss_count_d = miss_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            is_rd_q      <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            is_rd_q      <= is_rd_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
endmodule

// File: tb/tb_data_cache_ctrl.sv
// Self-checking bench for data_cache_ctrl: directed vector table, reset-in-fill sequence,
// and randomized traffic against a transparent-memory reference model.
module tb_data_cache_ctrl;
    localparam int NL = 4;

    logic        clk;
    logic        reset;
    logic        cpu_read;
    logic        cpu_write;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        is_hit;
    logic        is_miss;
    logic        mem_access_done;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [63:0] mem_rline;
    logic        mem_ready;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    data_cache_ctrl #(.NUM_LINES(NL), .WORDS_PER_LINE(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_read        (cpu_read),
        .cpu_write       (cpu_write),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_rdata       (cpu_rdata),
        .is_hit          (is_hit),
        .is_miss         (is_miss),
        .mem_access_done (mem_access_done),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rline       (mem_rline),
        .mem_ready       (mem_ready),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the cache is transparent, so every read returns main memory's
    // word; only residency (valid + tag per index) decides hit or miss.
    logic [15:0] mem [0:65535];
    logic        m_valid [NL];
    logic [15:0] m_tag   [NL];
    int          exp_hits;
    int          exp_misses;
    int          n_chk;
    int          n_fail;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic        hit;
        logic [15:0] rdata;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [15:0] a);
        return int'((a >> 2) % NL);
    endfunction

    function automatic logic [15:0] tag_of(input logic [15:0] a);
        return a / (4 * NL);
    endfunction

    function automatic logic model_hit(input logic [15:0] a);
        return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
    endfunction

    function automatic logic [63:0] line_of(input logic [15:0] a);
        logic [15:0] b;
        b = a & 16'hFFFC;
        return {mem[b + 16'd3], mem[b + 16'd2], mem[b + 16'd1], mem[b]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // Called just after a rising edge with the controller in IDLE; returns the same way.
    task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input int lat, input logic exp_hit,
                          input logic [15:0] exp_rdata, input string nm);
        logic req;
        logic busy;
        req  = rd | wr;
        busy = wr | (rd & !exp_hit);
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        mem_ready = req ? 1'b0 : 1'(($urandom_range(0, 3) == 0));
        @(negedge clk);
        chk({nm, "/hit_count"}, hit_count, 16'(exp_hits));
        chk({nm, "/miss_count"}, miss_count, 16'(exp_misses));
        chk({nm, "/is_hit"}, 16'(is_hit), 16'(req & exp_hit));
        chk({nm, "/is_miss"}, 16'(is_miss), 16'(req & !exp_hit));
        chk({nm, "/done"}, 16'(mem_access_done), 16'(!busy));
        chk({nm, "/rdata"}, cpu_rdata, (rd && !wr && exp_hit) ? exp_rdata : 16'h0);
        chk({nm, "/memreq_t0"}, 16'({mem_read, mem_write}), 16'h0);
        if (!req) begin
            chk({nm, "/idle_addr"}, mem_addr, 16'h0);
            chk({nm, "/idle_wdata"}, mem_wdata, 16'h0);
        end
        if (req && exp_hit) exp_hits++;
        if (req && !exp_hit) exp_misses++;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        if (busy) begin
            cpu_read  = 1'($urandom_range(0, 1));
            cpu_write = 1'($urandom_range(0, 1));
            cpu_addr  = 16'($urandom);
            cpu_wdata = 16'($urandom);
            for (int c = 0; c <= lat; c++) begin
                if (c == lat) begin
                    mem_ready = 1'b1;
                    mem_rline = line_of(addr);
                end
                @(negedge clk);
                chk({nm, "/mem_read"}, 16'(mem_read), 16'(!wr));
                chk({nm, "/mem_write"}, 16'(mem_write), 16'(wr));
                chk({nm, "/mem_addr"}, mem_addr, wr ? addr : (addr & 16'hFFFC));
                chk({nm, "/mem_wdata"}, mem_wdata, wr ? wdata : 16'h0);
                chk({nm, "/busy_done"}, 16'(mem_access_done), 16'h0);
                @(posedge clk);
                #1;
                mem_ready = 1'b0;
                mem_rline = 64'h0;
            end
            @(negedge clk);
            chk({nm, "/resp_done"}, 16'(mem_access_done), 16'h1);
            chk({nm, "/resp_rdata"}, cpu_rdata, wr ? 16'h0 : exp_rdata);
            chk({nm, "/resp_flags"}, 16'({is_hit, is_miss, mem_read, mem_write}), 16'h0);
            @(posedge clk);
            #1;
        end
        if (wr) begin
            mem[addr] = wdata;
        end else if (rd) begin
            m_valid[idx_of(addr)] = 1'b1;
            m_tag[idx_of(addr)]   = tag_of(addr);
        end
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
    endtask

    initial begin
        logic        rd;
        logic        wr;
        logic [15:0] a;
        logic [15:0] d;
        int          op;

        n_chk      = 0;
        n_fail     = 0;
        reset      = 1'b1;
        cpu_read   = 1'b0;
        cpu_write  = 1'b0;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        mem_rline  = '0;
        mem_ready  = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 40503) ^ 16'h3C3C;
        mem[16'h0010] = 16'hAAAA;
        mem[16'h0011] = 16'hBBBB;
        mem[16'h0012] = 16'hCCCC;
        mem[16'h0013] = 16'hDDDD;
        for (int i = 0; i < 4; i++) mem[16'h0050 + 16'(i)] = 16'h5000 + 16'(i);
        model_reset();

        vecs[0]  = '{1'b1, 1'b0, 16'h0013, 16'h0000, 4, 1'b0, 16'hDDDD};
        vecs[1]  = '{1'b1, 1'b0, 16'h0011, 16'h0000, 0, 1'b1, 16'hBBBB};
        vecs[2]  = '{1'b1, 1'b0, 16'h0053, 16'h0000, 2, 1'b0, 16'h5003};
        vecs[3]  = '{1'b1, 1'b0, 16'h0013, 16'h0000, 1, 1'b0, 16'hDDDD};
        vecs[4]  = '{1'b1, 1'b0, 16'h0052, 16'h0000, 0, 1'b0, 16'h5002};
        vecs[5]  = '{1'b0, 1'b1, 16'h0051, 16'h1234, 3, 1'b1, 16'h0000};
        vecs[6]  = '{1'b1, 1'b0, 16'h0051, 16'h0000, 0, 1'b1, 16'h1234};
        vecs[7]  = '{1'b0, 1'b1, 16'h0200, 16'h5678, 0, 1'b0, 16'h0000};
        vecs[8]  = '{1'b1, 1'b0, 16'h0200, 16'h0000, 2, 1'b0, 16'h5678};
        vecs[9]  = '{1'b1, 1'b0, 16'h0200, 16'h0000, 0, 1'b1, 16'h5678};
        vecs[10] = '{1'b1, 1'b1, 16'h0200, 16'hBEEF, 1, 1'b1, 16'h0000};
        vecs[11] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 0, 1'b1, 16'hBEEF};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset/done", 16'(mem_access_done), 16'h1);
        chk("reset/flags", 16'({is_hit, is_miss, mem_read, mem_write}), 16'h0);
        chk("reset/rdata", cpu_rdata, 16'h0);
        chk("reset/hit_count", hit_count, 16'h0);
        chk("reset/miss_count", miss_count, 16'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].lat,
                   vecs[i].hit, vecs[i].rdata, $sformatf("vec%0d", i));
        end
        @(negedge clk);
        chk("table/hit_count", hit_count, 16'd6);
        chk("table/miss_count", miss_count, 16'd6);
        @(posedge clk);
        #1;

        // Reset during the second FILL cycle, then a stray mem_ready in IDLE.
        cpu_read = 1'b1;
        cpu_addr = 16'h0300;
        @(negedge clk);
        chk("rstfill/t0_miss", 16'(is_miss), 16'h1);
        @(posedge clk);
        #1;
        cpu_read = 1'b0;
        cpu_addr = '0;
        @(negedge clk);
        chk("rstfill/fill1_mem_read", 16'(mem_read), 16'h1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("rstfill/mem_read_dropped", 16'(mem_read), 16'h0);
        chk("rstfill/done", 16'(mem_access_done), 16'h1);
        chk("rstfill/hit_count", hit_count, 16'h0);
        chk("rstfill/miss_count", miss_count, 16'h0);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rstfill/stray_ready_ignored", 16'({mem_read, mem_write, mem_access_done}), 16'h1);
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 16'h0013, 16'h0, 1, 1'b0, 16'hDDDD, "rstfill/reread");

        for (int n = 0; n < 400; n++) begin
            op = int'($urandom_range(0, 9));
            rd = (op >= 2 && op <= 6) || op == 9;
            wr = (op >= 7);
            a  = 16'($urandom_range(0, 127));
            d  = 16'($urandom);
            access(rd, wr, a, d, int'($urandom_range(0, 3)), model_hit(a), mem[a],
                   $sformatf("rnd%0d", n));
        end
        @(negedge clk);
        chk("final/hit_count", hit_count, 16'(exp_hits));
        chk("final/miss_count", miss_count, 16'(exp_misses));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
